// File: rtl/regfile_mp_if.sv
// ----------------------------------------------------------------------------
// regfile_mp_if
//   Bundles the decode/writeback facing signals of regfile_mp.
//   Packed layouts: write port k at [k*AWIDTH +: AWIDTH] / [k*DWIDTH +: DWIDTH],
//   read port r at [r*AWIDTH +: AWIDTH] / [r*DWIDTH +: DWIDTH].
//   master : issue/writeback side (drives writes, reads, scoreboard set)
//   slave  : the register file (returns DataR and BusyR)
// ----------------------------------------------------------------------------
interface regfile_mp_if #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 5,
    parameter int NREAD  = 2,
    parameter int NWRITE = 2
);
    logic [NWRITE-1:0]        RegWEn;
    logic [NWRITE*AWIDTH-1:0] AddrD;
    logic [NWRITE*DWIDTH-1:0] DataD;
    logic [NREAD*AWIDTH-1:0]  AddrR;
    logic [NREAD*DWIDTH-1:0]  DataR;
    logic                     SbSet;
    logic [AWIDTH-1:0]        SbAddr;
    logic [NREAD-1:0]         BusyR;

    modport master (
        output RegWEn, AddrD, DataD, AddrR, SbSet, SbAddr,
        input  DataR, BusyR
    );

    modport slave (
        input  RegWEn, AddrD, DataD, AddrR, SbSet, SbAddr,
        output DataR, BusyR
    );
endinterface

// File: rtl/regfile_mp.sv
// ----------------------------------------------------------------------------
// regfile_mp
//   Multi-port integer register file with hardwired-zero x0, optional
//   same-cycle write-to-read bypass, and a per-register busy scoreboard
//   used by issue logic to detect RAW hazards.
//
// Ports
//   clk : clock, all state changes on posedge
//   rst : synchronous active-high reset; clears registers and busy bits,
//         drops writes/SbSet of that cycle and disables bypass
//   bus : regfile_mp_if.slave
//         RegWEn/AddrD/DataD  write ports (higher index has priority)
//         AddrR -> DataR      combinational reads
//         SbSet/SbAddr        mark a register busy
//         BusyR               busy flag of each read port's register
// ----------------------------------------------------------------------------
module regfile_mp #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 5,
    parameter int NREAD  = 2,
    parameter int NWRITE = 2,
    parameter bit BYPASS = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    regfile_mp_if.slave bus
);
    localparam int DEPTH = 2 ** AWIDTH;

    logic [DWIDTH-1:0] regs_q [DEPTH];
    logic [DWIDTH-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;

    // Unpacked view of the write ports. wr_en already excludes x0 so that
    // neither the update nor the forwarding path ever has to special-case it.
    logic              wr_en   [NWRITE];
    logic [AWIDTH-1:0] wr_addr [NWRITE];
    logic [DWIDTH-1:0] wr_data [NWRITE];

    genvar gi;
    generate
        for (gi = 0; gi < NWRITE; gi++) begin : g_wr
            assign wr_addr[gi] = bus.AddrD[gi*AWIDTH +: AWIDTH];
            assign wr_data[gi] = bus.DataD[gi*DWIDTH +: DWIDTH];
            assign wr_en[gi]   = bus.RegWEn[gi] && (wr_addr[gi] != '0);
        end
    endgenerate

    // Next state. Ports are walked in ascending order so the highest enabled
    // port targeting an address is the last assignment and wins. The
    // scoreboard set is applied after all clears: a fresh producer issued in
    // the same cycle as a writeback keeps the register busy.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        for (int k = 0; k < NWRITE; k++) begin
            if (wr_en[k]) begin
                regs_d[wr_addr[k]] = wr_data[k];
                busy_d[wr_addr[k]] = 1'b0;
            end
        end
        if (bus.SbSet && (bus.SbAddr != '0)) begin
            busy_d[bus.SbAddr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    // Read ports: stored value, optionally overridden by a same-cycle write
    // (highest port wins). A forwarded read reports not-busy because the
    // value it returns is already the producer's result.
    generate
        for (gi = 0; gi < NREAD; gi++) begin : g_rd
            logic [AWIDTH-1:0] rd_addr;
            logic [DWIDTH-1:0] rd_data;
            logic              fwd_hit;

            assign rd_addr = bus.AddrR[gi*AWIDTH +: AWIDTH];

            always_comb begin
                rd_data = regs_q[rd_addr];
                fwd_hit = 1'b0;
                if (BYPASS && !rst) begin
                    for (int k = 0; k < NWRITE; k++) begin
                        if (wr_en[k] && (wr_addr[k] == rd_addr)) begin
                            fwd_hit = 1'b1;
                            rd_data = wr_data[k];
                        end
                    end
                end
                // x0 reads as zero regardless of stored or forwarded content
                if (rd_addr == '0) begin
                    rd_data = '0;
                end
            end

            assign bus.DataR[gi*DWIDTH +: DWIDTH] = rd_data;
            assign bus.BusyR[gi]                  = busy_q[rd_addr] & ~fwd_hit;
        end
    endgenerate
endmodule

// File: tb/tb_regfile_mp.sv
// ----------------------------------------------------------------------------
// tb_regfile_mp
//   Drives a BYPASS=1 and a BYPASS=0 instance with identical stimulus.
//   The driver computes expected read results from a plain array model and
//   queues them; a negedge monitor pops and compares against both DUTs.
// ----------------------------------------------------------------------------
module tb_regfile_mp;
    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NR    = 2;
    localparam int NW    = 2;
    localparam int DEPTH = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_mp_if #(.DWIDTH(DW), .AWIDTH(AW), .NREAD(NR), .NWRITE(NW)) bus_byp ();
    regfile_mp_if #(.DWIDTH(DW), .AWIDTH(AW), .NREAD(NR), .NWRITE(NW)) bus_nob ();

    regfile_mp #(.DWIDTH(DW), .AWIDTH(AW), .NREAD(NR), .NWRITE(NW), .BYPASS(1'b1)) dut_byp (
        .clk (clk),
        .rst (rst),
        .bus (bus_byp)
    );

    regfile_mp #(.DWIDTH(DW), .AWIDTH(AW), .NREAD(NR), .NWRITE(NW), .BYPASS(1'b0)) dut_nob (
        .clk (clk),
        .rst (rst),
        .bus (bus_nob)
    );

    // Reference model: architectural register contents and busy flags
    logic [DW-1:0] m_reg  [DEPTH];
    bit            m_busy [DEPTH];

    typedef struct {
        int               cyc;
        logic [NR*AW-1:0] addr;
        logic [NR*DW-1:0] d_byp;
        logic [NR*DW-1:0] d_nob;
        logic [NR-1:0]    b_byp;
        logic [NR-1:0]    b_nob;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cycle  = 0;

    task automatic cmp(input string name, input int cyc, input int port, input int addr,
                       input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d port=%0d addr=%0d got=%h want=%h", name, cyc, port, addr, act, exp);
        end
    endtask

    // Monitor: one expectation per cycle, compared half a period after the
    // driver applied that cycle's inputs.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            for (int r = 0; r < NR; r++) begin
                int a;
                a = int'(e.addr[r*AW +: AW]);
                cmp("DataR_bypass", e.cyc, r, a, bus_byp.DataR[r*DW +: DW], e.d_byp[r*DW +: DW]);
                cmp("DataR_nobypass", e.cyc, r, a, bus_nob.DataR[r*DW +: DW], e.d_nob[r*DW +: DW]);
                cmp("BusyR_bypass", e.cyc, r, a, DW'(bus_byp.BusyR[r]), DW'(e.b_byp[r]));
                cmp("BusyR_nobypass", e.cyc, r, a, DW'(bus_nob.BusyR[r]), DW'(e.b_nob[r]));
            end
            $display("cyc=%0d addrR0=%0d addrR1=%0d dataR_byp=%h dataR_nob=%h busy_byp=%b busy_nob=%b",
                     e.cyc, e.addr[0 +: AW], e.addr[AW +: AW], bus_byp.DataR, bus_nob.DataR,
                     bus_byp.BusyR, bus_nob.BusyR);
        end
    end

    // One clock cycle of stimulus. Expectations use the model state before
    // the edge; the model then advances by the architectural rules.
    task automatic step(input bit r, input logic [NW-1:0] en, input logic [NW*AW-1:0] ad,
                        input logic [NW*DW-1:0] dd, input logic [NR*AW-1:0] ar,
                        input bit sb, input logic [AW-1:0] sba, input bit chk);
        exp_t e;
        rst            = r;
        bus_byp.RegWEn = en;  bus_nob.RegWEn = en;
        bus_byp.AddrD  = ad;  bus_nob.AddrD  = ad;
        bus_byp.DataD  = dd;  bus_nob.DataD  = dd;
        bus_byp.AddrR  = ar;  bus_nob.AddrR  = ar;
        bus_byp.SbSet  = sb;  bus_nob.SbSet  = sb;
        bus_byp.SbAddr = sba; bus_nob.SbAddr = sba;

        if (chk) begin
            e.cyc  = cycle;
            e.addr = ar;
            for (int p = 0; p < NR; p++) begin
                int            a;
                logic [DW-1:0] stored;
                logic [DW-1:0] fval;
                bit            fwd;
                a      = int'(ar[p*AW +: AW]);
                stored = (a == 0) ? '0 : m_reg[a];
                fwd    = 1'b0;
                fval   = '0;
                if (!r && a != 0) begin
                    for (int k = 0; k < NW; k++) begin
                        if (en[k] && int'(ad[k*AW +: AW]) == a) begin
                            fwd  = 1'b1;
                            fval = dd[k*DW +: DW];
                        end
                    end
                end
                e.d_nob[p*DW +: DW] = stored;
                e.d_byp[p*DW +: DW] = fwd ? fval : stored;
                e.b_nob[p]          = m_busy[a];
                e.b_byp[p]          = m_busy[a] && !fwd;
            end
            exp_q.push_back(e);
        end

        if (r) begin
            for (int i = 0; i < DEPTH; i++) begin
                m_reg[i]  = '0;
                m_busy[i] = 1'b0;
            end
        end else begin
            for (int k = 0; k < NW; k++) begin
                int a;
                a = int'(ad[k*AW +: AW]);
                if (en[k] && a != 0) begin
                    m_reg[a]  = dd[k*DW +: DW];
                    m_busy[a] = 1'b0;
                end
            end
            if (sb && sba != 0) m_busy[int'(sba)] = 1'b1;
        end

        @(posedge clk);
        #1;
        cycle++;
    endtask

    initial begin
        // Initial reset (outputs undefined before it, so not checked)
        step(1'b1, '0, '0, '0, '0, 1'b0, '0, 1'b0);

        // 1: every address reads 0 and not busy after reset
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, '0, '0, '0, {AW'(31 - i), AW'(i)}, 1'b0, '0, 1'b1);
        end

        // 2: write x15 via port 0, then read back
        step(1'b0, 2'b01, {5'd0, 5'd15}, {32'd0, 32'hDEADBEAF}, {5'd15, 5'd15}, 1'b0, '0, 1'b1);
        step(1'b0, 2'b00, '0, '0, {5'd15, 5'd15}, 1'b0, '0, 1'b1);

        // 3: writes to x0 are ignored
        step(1'b0, 2'b01, {5'd0, 5'd0}, {32'd0, 32'hFFFFFFFF}, {5'd0, 5'd0}, 1'b0, '0, 1'b1);
        step(1'b0, 2'b00, '0, '0, {5'd0, 5'd0}, 1'b0, '0, 1'b1);

        // 4: same-address collision, port 1 wins
        step(1'b0, 2'b11, {5'd7, 5'd7}, {32'h22222222, 32'h11111111}, {5'd7, 5'd7}, 1'b0, '0, 1'b1);
        step(1'b0, 2'b00, '0, '0, {5'd7, 5'd7}, 1'b0, '0, 1'b1);

        // 5: scoreboard set / clear / set-wins
        step(1'b0, 2'b00, '0, '0, {5'd9, 5'd9}, 1'b1, 5'd9, 1'b1);
        step(1'b0, 2'b00, '0, '0, {5'd9, 5'd9}, 1'b0, '0, 1'b1);
        step(1'b0, 2'b10, {5'd9, 5'd0}, {32'h5, 32'h0}, {5'd9, 5'd9}, 1'b0, '0, 1'b1);
        step(1'b0, 2'b00, '0, '0, {5'd9, 5'd9}, 1'b0, '0, 1'b1);
        step(1'b0, 2'b01, {5'd0, 5'd9}, {32'h0, 32'h6}, {5'd9, 5'd9}, 1'b1, 5'd9, 1'b1);
        step(1'b0, 2'b00, '0, '0, {5'd9, 5'd9}, 1'b0, '0, 1'b1);

        // 6: reset together with a write and SbSet drops both
        step(1'b0, 2'b01, {5'd0, 5'd3}, {32'h0, 32'h1}, {5'd3, 5'd15}, 1'b1, 5'd3, 1'b1);
        step(1'b1, 2'b01, {5'd0, 5'd3}, {32'h0, 32'hA5A5A5A5}, {5'd3, 5'd3}, 1'b1, 5'd3, 1'b1);
        step(1'b0, 2'b00, '0, '0, {5'd3, 5'd15}, 1'b0, '0, 1'b1);

        // Random traffic, addresses biased low to provoke collisions/hazards
        for (int n = 0; n < 600; n++) begin
            logic [NW-1:0]    en;
            logic [NW*AW-1:0] ad;
            logic [NW*DW-1:0] dd;
            logic [NR*AW-1:0] ar;
            for (int k = 0; k < NW; k++) begin
                ad[k*AW +: AW] = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31))
                                                             : AW'($urandom_range(0, 7));
                dd[k*DW +: DW] = DW'($urandom);
                en[k]          = $urandom_range(0, 1) == 1;
            end
            for (int p = 0; p < NR; p++) begin
                ar[p*AW +: AW] = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31))
                                                             : AW'($urandom_range(0, 7));
            end
            step($urandom_range(0, 59) == 0, en, ad, dd, ar,
                 $urandom_range(0, 2) == 0, AW'($urandom_range(0, 7)), 1'b1);
        end

        // Drain with a bounded wait
        for (int w = 0; w < 5 && exp_q.size() != 0; w++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d want=0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
